// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32 pipeline: stage enables,
// bubble/flush strobes, E-stage forwarding, dmem wait/timeout FSM, perf counters.
module pipeline_ctrl #(
   parameter int DWAIT_MAX = 16,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1_D,
   input  logic [4:0]       Rs2_D,
   input  logic             rs1_used_D,
   input  logic             rs2_used_D,
   input  logic [4:0]       Rs1_E,
   input  logic [4:0]       Rs2_E,
   input  logic [4:0]       Rd_E,
   input  logic             MemRead_E,
   input  logic             redirect_E,
   input  logic             RegWrite_M,
   input  logic [4:0]       Rd_M,
   input  logic             dmem_req_M,
   input  logic             dmem_ready,
   input  logic             imem_ready,
   input  logic             RegWrite_W,
   input  logic [4:0]       Rd_W,
   input  logic             ebreak_W,
   output logic             en_F,
   output logic             en_D,
   output logic             en_E,
   output logic             en_M,
   output logic             flush_D,
   output logic             flush_E,
   output logic             flush_W,
   output logic [1:0]       fwdA_E,
   output logic [1:0]       fwdB_E,
   output logic             halted,
   output logic             bus_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam int WC_W = (DWAIT_MAX > 2) ? $clog2(DWAIT_MAX) : 1;

   typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

   state_t          state, state_nxt;
   logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
   logic            bus_err_nxt;
   logic            mem_stall, load_use;

   assign mem_stall = dmem_req_M & ~dmem_ready;
   assign load_use  = MemRead_E & (Rd_E != 5'd0) &
                      ((rs1_used_D & (Rd_E == Rs1_D)) | (rs2_used_D & (Rd_E == Rs2_D)));

   always_comb begin
      en_F         = 1'b0;
      en_D         = 1'b0;
      en_E         = 1'b0;
      en_M         = 1'b0;
      flush_D      = 1'b0;
      flush_E      = 1'b0;
      flush_W      = 1'b0;
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      bus_err_nxt  = bus_err;

      if (rst || state == HALT) begin
         // everything frozen
      end else if (mem_stall) begin
         flush_W = 1'b1;
      end else if (redirect_E) begin
         {en_F, en_D, en_E, en_M} = 4'hf;
         flush_D = 1'b1;
         flush_E = 1'b1;
      end else if (load_use) begin
         {en_E, en_M} = 2'b11;
         flush_E = 1'b1;
      end else if (!imem_ready) begin
         {en_D, en_E, en_M} = 3'b111;
         flush_D = 1'b1;
      end else begin
         {en_F, en_D, en_E, en_M} = 4'hf;
      end

      // ebreak wins over a coincident stall; a retiring ebreak right as a
      // DWAIT ends must also halt, otherwise it would be lost.
      case (state)
         RUN: begin
            if (ebreak_W) begin
               state_nxt = HALT;
            end else if (mem_stall) begin
               state_nxt    = DWAIT;
               wait_cnt_nxt = WC_W'(1);
            end
         end
         DWAIT: begin
            if (ebreak_W) begin
               state_nxt    = HALT;
               wait_cnt_nxt = '0;
            end else if (!mem_stall) begin
               state_nxt    = RUN;
               wait_cnt_nxt = '0;
            end else if (wait_cnt == WC_W'(DWAIT_MAX - 1)) begin
               state_nxt    = HALT;
               wait_cnt_nxt = '0;
               bus_err_nxt  = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + 1'b1;
            end
         end
         default: state_nxt = HALT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         wait_cnt  <= '0;
         bus_err   <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         bus_err  <= bus_err_nxt;
         if (!en_F && state != HALT && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
         if ((flush_D || flush_E) && flush_cnt != '1)
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

   assign halted = (state == HALT);

   // M result is younger than W, so it wins when both match
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      if (RegWrite_M && Rd_M != 5'd0 && Rd_M == rs)      return 2'b10;
      else if (RegWrite_W && Rd_W != 5'd0 && Rd_W == rs) return 2'b01;
      else                                               return 2'b00;
   endfunction

   assign fwdA_E = rst ? 2'b00 : fwd_sel(Rs1_E);
   assign fwdB_E = rst ? 2'b00 : fwd_sel(Rs2_E);
endmodule
